// File: rtl/ls_mem_arbiter.sv
// Arbitrates the shared data-memory port between scalar single-word accesses and
// matrix strided bursts. Optional wait counters are built when LS_MEM_ARB_PERF_EN is defined.
module ls_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ROWS_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              s_ren,
  input  logic              s_wen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_hit,
  input  logic              m_start,
  input  logic              m_wen,
  input  logic [ADDR_W-1:0] m_base,
  input  logic [ADDR_W-1:0] m_stride,
  input  logic [ROWS_W-1:0] m_rows,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_busy,
  output logic [ROWS_W-1:0] m_row_idx,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_rvalid,
  output logic              m_done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_hit
`ifdef LS_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_s_wait,
  output logic [31:0]       perf_m_wait
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, S_ACC, M_ACC, BUBBLE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_wr;
  logic              busy;
  logic              b_wen;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] b_stride;
  logic [ROWS_W-1:0] b_rows;
  logic [ROWS_W-1:0] row_idx;
  logic [SW-1:0]     streak;
  logic              s_pend, m_pend, grant_s, grant_m, last_word;

  assign m_busy    = busy;
  assign m_row_idx = row_idx;

  always_comb begin
    s_pend    = s_ren | s_wen;
    m_pend    = busy & (row_idx != b_rows);
    last_word = ({1'b0, row_idx} + (ROWS_W + 1)'(1)) == {1'b0, b_rows};
    grant_s   = (state == IDLE) & s_pend & (~m_pend | (streak < LIMIT));
    grant_m   = (state == IDLE) & m_pend & (~s_pend | (streak >= LIMIT));
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    s_hit     = 1'b0;
    s_rdata   = '0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    // An empty burst completes in the cycle after it was accepted.
    m_done    = busy & (b_rows == '0);
    case (state)
      IDLE: begin
        if (grant_s)      state_nxt = S_ACC;
        else if (grant_m) state_nxt = M_ACC;
      end
      S_ACC: begin
        mem_ren   = ~acc_wr;
        mem_wen   = acc_wr;
        mem_addr  = acc_addr;
        mem_wdata = acc_wdata;
        if (mem_hit) begin
          s_hit     = 1'b1;
          s_rdata   = mem_rdata;
          state_nxt = BUBBLE;
        end
      end
      M_ACC: begin
        mem_ren   = ~acc_wr;
        mem_wen   = acc_wr;
        mem_addr  = acc_addr;
        mem_wdata = acc_wdata;
        if (mem_hit) begin
          m_rvalid  = 1'b1;
          m_rdata   = mem_rdata;
          m_done    = last_word;
          state_nxt = BUBBLE;
        end
      end
      BUBBLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_wr    <= 1'b0;
      busy      <= 1'b0;
      b_wen     <= 1'b0;
      b_addr    <= '0;
      b_stride  <= '0;
      b_rows    <= '0;
      row_idx   <= '0;
      streak    <= '0;
    end else begin
      if (grant_s) begin
        acc_addr  <= s_addr;
        acc_wdata <= s_wdata;
        acc_wr    <= s_wen;
      end else if (grant_m) begin
        acc_addr  <= b_addr;
        acc_wdata <= m_wdata;
        acc_wr    <= b_wen;
      end
      if (grant_m || m_done)
        streak <= '0;
      else if (grant_s && m_pend && streak != LIMIT)
        streak <= streak + SW'(1);
      if (!busy && m_start) begin
        busy     <= 1'b1;
        b_wen    <= m_wen;
        b_addr   <= m_base;
        b_stride <= m_stride;
        b_rows   <= m_rows;
        row_idx  <= '0;
      end else begin
        if (state == M_ACC && mem_hit) begin
          row_idx <= row_idx + ROWS_W'(1);
          b_addr  <= b_addr + b_stride;
        end
        if (m_done) busy <= 1'b0;
      end
    end
  end

`ifdef LS_MEM_ARB_PERF_EN
  logic s_wait, m_wait;
  assign s_wait = s_pend & ~grant_s & (state != S_ACC);
  assign m_wait = m_pend & ~grant_m & (state != M_ACC);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_s_wait <= '0;
      perf_m_wait <= '0;
    end else begin
      if (s_wait && perf_s_wait != '1) perf_s_wait <= perf_s_wait + 32'd1;
      if (m_wait && perf_m_wait != '1) perf_m_wait <= perf_m_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ls_mem_arbiter.sv
// Bench for ls_mem_arbiter: directed scenarios plus randomized concurrent scalar/burst
// traffic checked against a reference memory and burst address arithmetic.
module tb_ls_mem_arbiter;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        s_ren = 1'b0, s_wen = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0, s_rdata;
  logic        s_hit;
  logic        m_start = 1'b0, m_wen = 1'b0;
  logic [31:0] m_base = '0, m_stride = '0;
  logic [2:0]  m_rows = '0;
  logic [31:0] m_wdata;
  logic        m_busy;
  logic [2:0]  m_row_idx;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_done;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_hit = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat_cfg = 0;
  bit rand_lat = 1'b0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] wbuf    [8];

  ls_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ROWS_W(3), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_hit(s_hit),
    .m_start(m_start), .m_wen(m_wen), .m_base(m_base), .m_stride(m_stride),
    .m_rows(m_rows), .m_wdata(m_wdata), .m_busy(m_busy), .m_row_idx(m_row_idx),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_done(m_done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_hit(mem_hit)
  );

  initial forever #5 CLK = ~CLK;

  // Matrix requester presents store data for the word it is currently on.
  always_comb m_wdata = wbuf[m_row_idx];

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : def_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
  endfunction

  // Memory responder: hit after (latency+1) cycles of a held request.
  initial begin
    int cnt;
    int cur_lat;
    cnt = 0;
    cur_lat = 0;
    forever begin
      @(posedge CLK);
      #1;
      mem_hit   = 1'b0;
      mem_rdata = '0;
      if (nRST && (mem_ren || mem_wen)) begin
        if (cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 2)) : lat_cfg;
        cnt++;
        if (cnt > cur_lat) begin
          mem_hit = 1'b1;
          cnt = 0;
          if (mem_wen) mem[mem_addr] = mem_wdata;
          else         mem_rdata = rd_mem(mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic run_burst(input logic w, input logic [31:0] base, input logic [31:0] stride,
                           input logic [2:0] rows);
    int i;
    int dones;
    int cyc;
    logic [31:0] ea;
    i = 0;
    dones = 0;
    cyc = 0;
    for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
    m_wen = w; m_base = base; m_stride = stride; m_rows = rows; m_start = 1'b1;
    @(negedge CLK);
    m_start = 1'b0;
    while (dones == 0 && cyc < 300) begin
      if (m_rvalid) begin
        ea = base + stride * 32'(i);
        checks++;
        if (m_row_idx !== 3'(i)) begin
          errors++; $display("FAIL burst_row_idx got %0d want %0d", m_row_idx, i);
        end
        checks++;
        if (mem_addr !== ea || mem_wen !== w || mem_ren !== ~w) begin
          errors++; $display("FAIL burst_addr got %h (wen %b) want %h (wen %b)", mem_addr, mem_wen, ea, w);
        end
        checks++;
        if (w) begin
          if (mem_wdata !== wbuf[i]) begin
            errors++; $display("FAIL burst_wdata got %h want %h", mem_wdata, wbuf[i]);
          end
          ref_mem[ea] = wbuf[i];
        end else if (m_rdata !== ref_rd(ea)) begin
          errors++; $display("FAIL burst_rdata got %h want %h", m_rdata, ref_rd(ea));
        end
        i++;
      end
      if (m_done) begin
        dones++;
        checks++;
        if (i != int'(rows) || (rows != 0 && !m_rvalid)) begin
          errors++; $display("FAIL burst_done got words %0d rvalid %b want words %0d", i, m_rvalid, rows);
        end
      end
      if (dones == 0) begin
        @(negedge CLK);
        cyc++;
      end
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL burst_timeout got done %0d want 1", dones);
    end
    @(negedge CLK);
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      errors++; $display("FAIL burst_idle got busy %b done %b want 0 0", m_busy, m_done);
    end
  endtask

  task automatic run_scalar(input int n);
    logic        wr;
    logic [31:0] a, d;
    int          cyc;
    for (int j = 0; j < n; j++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      d  = $urandom;
      s_addr = a; s_wdata = d; s_wen = wr;
      s_ren = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc = 0;
      do begin
        @(negedge CLK);
        cyc++;
      end while (!s_hit && cyc < 300);
      checks++;
      if (!s_hit) begin
        errors++; $display("FAIL scalar_timeout got s_hit 0 want 1");
      end else if (wr) begin
        if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== a || mem_wdata !== d) begin
          errors++; $display("FAIL scalar_store got %b %h %h want 1 %h %h", mem_wen, mem_addr, mem_wdata, a, d);
        end
        ref_mem[a] = d;
      end else if (mem_ren !== 1'b1 || s_rdata !== ref_rd(a)) begin
        errors++; $display("FAIL scalar_load got %h want %h", s_rdata, ref_rd(a));
      end
      s_ren = 1'b0; s_wen = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({mem_ren, mem_wen, s_hit, m_busy, m_rvalid, m_done} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {mem_ren, mem_wen, s_hit, m_busy, m_rvalid, m_done});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || m_row_idx !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", mem_addr, mem_wdata, m_row_idx);
    end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_scalar_load();
    int nren;
    int hits;
    int first;
    logic [31:0] exp;
    nren = 0; hits = 0; first = -1;
    lat_cfg = 1;
    exp = ref_rd(32'h100);
    s_addr = 32'h100; s_ren = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (mem_ren && mem_addr == 32'h100) begin
        nren++;
        if (first < 0) first = c;
      end
      if (s_hit) begin
        hits++;
        checks++;
        if (s_rdata !== exp) begin
          errors++; $display("FAIL sload_data got %h want %h", s_rdata, exp);
        end
        s_ren = 1'b0;
      end
    end
    checks++;
    if (hits != 1) begin errors++; $display("FAIL sload_hits got %0d want 1", hits); end
    checks++;
    if (nren != 2) begin errors++; $display("FAIL sload_addr_cycles got %0d want 2", nren); end
    checks++;
    if (first != 1) begin errors++; $display("FAIL sload_latency got %0d want 1", first); end
    lat_cfg = 0;
  endtask

  task automatic test_scalar_store();
    logic [31:0] d;
    d = $urandom;
    lat_cfg = 0;
    s_addr = 32'h204; s_wdata = d; s_ren = 1'b1; s_wen = 1'b1;
    @(negedge CLK);
    checks++;
    if (s_hit !== 1'b1 || mem_wen !== 1'b1 || mem_ren !== 1'b0) begin
      errors++; $display("FAIL sstore_flags got hit %b wen %b ren %b want 1 1 0", s_hit, mem_wen, mem_ren);
    end
    checks++;
    if (mem_addr !== 32'h204 || mem_wdata !== d) begin
      errors++; $display("FAIL sstore_bus got %h %h want 00000204 %h", mem_addr, mem_wdata, d);
    end
    s_ren = 1'b0; s_wen = 1'b0;
    ref_mem[32'h204] = d;
    @(negedge CLK);
    checks++;
    if (mem_wen !== 1'b0 || s_hit !== 1'b0 || rd_mem(32'h204) !== d) begin
      errors++; $display("FAIL sstore_bubble got wen %b mem %h want 0 %h", mem_wen, rd_mem(32'h204), d);
    end
  endtask

  task automatic test_burst_load();
    lat_cfg = 0;
    run_burst(1'b0, 32'h1000, 32'h10, 3'd4);
  endtask

  task automatic test_burst_store();
    run_burst(1'b1, 32'h1100, 32'h4, 3'd7);
    run_burst(1'b0, 32'h1100, 32'h4, 3'd7);
  endtask

  task automatic test_wrap();
    run_burst(1'b1, 32'hFFFF_FFF8, 32'h10, 3'd2);
    run_burst(1'b0, 32'hFFFF_FFF8, 32'h10, 3'd2);
    checks++;
    if (rd_mem(32'h0000_0008) !== ref_rd(32'h0000_0008) || !mem.exists(32'h0000_0008)) begin
      errors++; $display("FAIL wrap_word1 got %h want %h", rd_mem(32'h8), ref_rd(32'h8));
    end
  endtask

  task automatic test_zero_rows();
    m_wen = 1'b0; m_base = 32'h500; m_stride = 32'h4; m_rows = 3'd0; m_start = 1'b1;
    @(negedge CLK);
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b1 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL zero_rows_done got done %b busy %b ren %b wen %b want 1 1 0 0", m_done, m_busy, mem_ren, mem_wen);
    end
    m_rows = 3'd3;  // still asserted while busy: must be ignored
    @(negedge CLK);
    m_start = 1'b0;
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL zero_rows_after got done %b busy %b ren %b want 0 0 0", m_done, m_busy, mem_ren);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_starvation();
    int seq[$];
    bit done_seen;
    done_seen = 1'b0;
    lat_cfg = 0;
    m_wen = 1'b0; m_base = 32'h2000; m_stride = 32'h4; m_rows = 3'd4; m_start = 1'b1;
    @(negedge CLK);
    m_start = 1'b0;
    s_ren = 1'b1; s_wen = 1'b0; s_addr = 32'h8000_0040;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      @(negedge CLK);
      if (s_hit) seq.push_back(0);
      if (m_rvalid) seq.push_back(1);
      if (m_done) done_seen = 1'b1;
    end
    s_ren = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (!done_seen || seq.size() != 20) begin
      errors++; $display("FAIL starve_len got done %b grants %0d want 1 20", done_seen, seq.size());
    end
    for (int k = 0; k < seq.size() && k < 20; k++) begin
      checks++;
      if (seq[k] != int'(k % 5 == 4)) begin
        errors++; $display("FAIL starve_order grant %0d got %0d want %0d", k, seq[k], int'(k % 5 == 4));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    lat_cfg = 3;
    m_wen = 1'b0; m_base = 32'h3000; m_stride = 32'h8; m_rows = 3'd4; m_start = 1'b1;
    @(negedge CLK);
    m_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mem_ren) break;
      @(negedge CLK);
    end
    checks++;
    if (mem_ren !== 1'b1) begin errors++; $display("FAIL rst_mid_start got ren %b want 1", mem_ren); end
    nRST = 1'b0;
    @(negedge CLK);
    checks++;
    if (mem_ren !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_row_idx !== '0) begin
      errors++; $display("FAIL rst_mid_abort got ren %b busy %b done %b want 0 0 0", mem_ren, m_busy, m_done);
    end
    nRST = 1'b1;
    lat_cfg = 0;
    @(negedge CLK);
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_nodone got done %b busy %b want 0 0", m_done, m_busy);
    end
    run_burst(1'b0, 32'h4000, 32'h4, 3'd3);
  endtask

  task automatic test_random();
    rand_lat = 1'b1;
    for (int it = 0; it < 8; it++) begin
      logic [31:0] b, st;
      logic [2:0]  r;
      logic        w;
      int          ns;
      b  = $urandom & 32'h0000_FFFC;
      st = 32'($urandom_range(0, 64)) << 2;
      r  = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      ns = $urandom_range(0, 6);
      fork
        run_burst(w, b, st, r);
        run_scalar(ns);
      join
      @(negedge CLK);
    end
    rand_lat = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) wbuf[k] = '0;
    test_reset();
    test_scalar_load();
    test_scalar_store();
    test_burst_load();
    test_burst_store();
    test_wrap();
    test_zero_rows();
    test_starvation();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
